// File: rtl/vending_ctrl.sv
// Coin-operated vending controller: accumulates credit from two coin types,
// pulses a vend strobe on sale, and hands change or refunds to a dispenser.
module vending_ctrl #(
    parameter int CREDIT_W   = 4,
    parameter int PRICE      = 3,
    parameter int COIN_A_VAL = 1,
    parameter int COIN_B_VAL = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          in,
    input  logic                cancel,
    input  logic                disp_ready,
    output logic                out,
    output logic [CREDIT_W-1:0] change,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        VEND    = 3'd2,
        CHANGE  = 3'd3,
        REFUND  = 3'd4
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_V  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] COIN_A_V = CREDIT_W'(COIN_A_VAL);
    localparam logic [CREDIT_W-1:0] COIN_B_V = CREDIT_W'(COIN_B_VAL);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic [CREDIT_W-1:0] coin_val;
    logic                coin_ok;
    logic [CREDIT_W-1:0] sum;

    // Code 11 is reserved and decodes to "no coin" like 00.
    always_comb begin
        coin_val = '0;
        coin_ok  = 1'b0;
        case (in)
            2'b01: begin
                coin_val = COIN_A_V;
                coin_ok  = 1'b1;
            end
            2'b10: begin
                coin_val = COIN_B_V;
                coin_ok  = 1'b1;
            end
            default: ;
        endcase
    end

    assign sum = credit_q + coin_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            change_q <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            change_q <= change_d;
        end
    end

    // A coin arriving with cancel is folded into the refund so it is never lost.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        change_d = change_q;
        case (state_q)
            IDLE: begin
                credit_d = '0;
                if (coin_ok) begin
                    if (cancel) begin
                        state_d  = REFUND;
                        change_d = coin_val;
                    end else begin
                        credit_d = coin_val;
                        state_d  = (coin_val >= PRICE_V) ? VEND : COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (cancel) begin
                    state_d  = REFUND;
                    change_d = sum;
                    credit_d = '0;
                end else begin
                    credit_d = sum;
                    if (sum >= PRICE_V) begin
                        state_d = VEND;
                    end
                end
            end
            VEND: begin
                credit_d = '0;
                if (credit_q > PRICE_V) begin
                    state_d  = CHANGE;
                    change_d = credit_q - PRICE_V;
                end else begin
                    state_d = IDLE;
                end
            end
            CHANGE, REFUND: begin
                if (disp_ready) begin
                    state_d  = IDLE;
                    change_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
                change_d = '0;
            end
        endcase
    end

    assign out          = (state_q == VEND);
    assign change_valid = (state_q == CHANGE) || (state_q == REFUND);
    assign busy         = (state_q == VEND) || (state_q == CHANGE) || (state_q == REFUND);
    assign credit       = credit_q;
    assign change       = change_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Testbench for vending_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_vending_ctrl;

    localparam int CREDIT_W = 4;
    localparam int PRICE    = 3;
    localparam int COIN_A   = 1;
    localparam int COIN_B   = 2;

    logic                clk;
    logic                rst;
    logic [1:0]          in;
    logic                cancel;
    logic                disp_ready;
    logic                out;
    logic [CREDIT_W-1:0] change;
    logic                change_valid;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    int tests  = 0;
    int failed = 0;

    // Model: money held, a sale in progress, and an amount owed to the customer.
    int m_credit = 0;
    bit m_vend   = 0;
    bit m_owe    = 0;
    int m_owed   = 0;
    bit check_en = 0;

    vending_ctrl #(
        .CREDIT_W  (CREDIT_W),
        .PRICE     (PRICE),
        .COIN_A_VAL(COIN_A),
        .COIN_B_VAL(COIN_B)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in),
        .cancel      (cancel),
        .disp_ready  (disp_ready),
        .out         (out),
        .change      (change),
        .change_valid(change_valid),
        .credit      (credit),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int coin_value(input logic [1:0] c);
        if (c == 2'b01) return COIN_A;
        if (c == 2'b10) return COIN_B;
        return 0;
    endfunction

    always @(posedge clk) begin
        int v;
        v = coin_value(in);
        if (rst) begin
            m_credit = 0;
            m_vend   = 0;
            m_owe    = 0;
            m_owed   = 0;
        end else if (m_owe) begin
            if (disp_ready) begin
                m_owe  = 0;
                m_owed = 0;
            end
        end else if (m_vend) begin
            m_vend = 0;
            if (m_credit > PRICE) begin
                m_owe  = 1;
                m_owed = m_credit - PRICE;
            end
            m_credit = 0;
        end else if (cancel && (m_credit + v) > 0) begin
            m_owe    = 1;
            m_owed   = m_credit + v;
            m_credit = 0;
        end else begin
            m_credit = m_credit + v;
            if (m_credit >= PRICE) m_vend = 1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            tests++;
            if (out !== m_vend || change_valid !== m_owe || busy !== (m_vend | m_owe) ||
                int'(credit) != m_credit || (m_owe && int'(change) != m_owed)) begin
                failed++;
                $display("[TB] FAIL model t=%0t: out=%b cv=%b busy=%b credit=%0d change=%0d, required out=%b cv=%b busy=%b credit=%0d change=%0d",
                         $time, out, change_valid, busy, credit, change,
                         m_vend, m_owe, m_vend | m_owe, m_credit, m_owed);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic [1:0] c, input logic k, input logic d);
        rst        = r;
        in         = c;
        cancel     = k;
        disp_ready = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic e_out, input logic e_cv,
                               input int e_change, input int e_credit, input logic e_busy,
                               input bit chk_change);
        tests++;
        if (out !== e_out || change_valid !== e_cv || busy !== e_busy ||
            int'(credit) != e_credit || (chk_change && int'(change) != e_change)) begin
            failed++;
            $display("[TB] FAIL %s: out=%b cv=%b busy=%b credit=%0d change=%0d, required out=%b cv=%b busy=%b credit=%0d change=%0d",
                     name, out, change_valid, busy, credit, change,
                     e_out, e_cv, e_busy, e_credit, e_change);
        end
    endtask

    initial begin
        rst = 1'b1; in = 2'b00; cancel = 1'b0; disp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_en = 1;
        checkOutput("reset", 0, 0, 0, 0, 0, 1);

        // Three A coins complete the price exactly.
        applyStimulus(0, 2'b01, 0, 0); checkOutput("a1", 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 2'b01, 0, 0); checkOutput("a2", 0, 0, 0, 2, 0, 0);
        applyStimulus(0, 2'b01, 0, 0); checkOutput("a3_vend", 1, 0, 0, 3, 1, 0);
        applyStimulus(0, 2'b00, 0, 0); checkOutput("a3_idle", 0, 0, 0, 0, 0, 0);

        // Overpay with two B coins, dispenser stalls three cycles.
        applyStimulus(0, 2'b10, 0, 0); checkOutput("b1", 0, 0, 0, 2, 0, 0);
        applyStimulus(0, 2'b10, 0, 0); checkOutput("b2_vend", 1, 0, 0, 4, 1, 0);
        applyStimulus(0, 2'b00, 0, 0); checkOutput("chg0", 0, 1, 1, 0, 1, 1);
        applyStimulus(0, 2'b01, 0, 0); checkOutput("chg1_coin_ignored", 0, 1, 1, 0, 1, 1);
        applyStimulus(0, 2'b01, 1, 0); checkOutput("chg2_cancel_ignored", 0, 1, 1, 0, 1, 1);
        applyStimulus(0, 2'b00, 0, 1); checkOutput("chg_done", 0, 0, 0, 0, 0, 0);

        // Cancel after one coin refunds it.
        applyStimulus(0, 2'b01, 0, 0); checkOutput("c_coin", 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 2'b00, 1, 0); checkOutput("c_refund", 0, 1, 1, 0, 1, 1);
        applyStimulus(0, 2'b00, 0, 1); checkOutput("c_done", 0, 0, 0, 0, 0, 0);

        // Completing coin with cancel: refund everything, no vend.
        applyStimulus(0, 2'b01, 0, 0); checkOutput("cw_coin", 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 2'b10, 1, 0); checkOutput("cw_refund", 0, 1, 3, 0, 1, 1);
        applyStimulus(0, 2'b00, 0, 1); checkOutput("cw_done", 0, 0, 0, 0, 0, 0);

        // Idle cancel alone, reserved code, and ready with nothing pending.
        applyStimulus(0, 2'b00, 1, 1); checkOutput("idle_cancel", 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 2'b11, 0, 0); checkOutput("reserved", 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 2'b10, 1, 0); checkOutput("idle_coin_cancel", 0, 1, 2, 0, 1, 1);
        applyStimulus(0, 2'b00, 0, 1); checkOutput("icc_done", 0, 0, 0, 0, 0, 0);

        // Reset in the middle of change, then an immediate coin.
        applyStimulus(0, 2'b10, 0, 0);
        applyStimulus(0, 2'b10, 0, 0);
        applyStimulus(0, 2'b00, 0, 0); checkOutput("pre_rst_chg", 0, 1, 1, 0, 1, 1);
        applyStimulus(1, 2'b01, 1, 0); checkOutput("mid_rst", 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 2'b10, 0, 0); checkOutput("post_rst_coin", 0, 0, 0, 2, 0, 0);
        applyStimulus(0, 2'b00, 1, 0);
        applyStimulus(0, 2'b00, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          2'($urandom_range(0, 3)),
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 1) == 1));
        end

        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
